nios2_ocimem_arbiter: RTL and testbench

NIOS2_OCIMEM_ARBITER -- requirements
Module: nios2_ocimem_arbiter

---
 rtl/nios2_ocimem_arbiter_if.sv | 49 ++++
 rtl/nios2_ocimem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_ocimem_arbiter_if.sv
// Bus bundle for the OCI memory arbiter: JTAG monitor port, Avalon-MM host port
// and the single-port RAM port. The arbiter uses the slave modport; the
// environment (hosts and RAM) uses the master modport.
interface nios2_ocimem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    // JTAG monitor side
    logic              jtag_req;
    logic              jtag_wr;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;
    logic              jtag_clr_err;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    // Avalon-MM host side
    logic              avs_read;
    logic              avs_write;
    logic [ADDR_W-1:0] avs_address;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    // RAM side, read latency 1
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  jtag_req, jtag_wr, jtag_addr, jtag_wdata, jtag_clr_err,
        output MonDReg, monitor_ready, monitor_error,
        input  avs_read, avs_write, avs_address, avs_writedata,
        output avs_readdata, avs_waitrequest,
        output ram_addr, ram_wr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output jtag_req, jtag_wr, jtag_addr, jtag_wdata, jtag_clr_err,
        input  MonDReg, monitor_ready, monitor_error,
        output avs_read, avs_write, avs_address, avs_writedata,
        input  avs_readdata, avs_waitrequest,
        input  ram_addr, ram_wr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/nios2_ocimem_arbiter.sv
// OCI memory arbiter: shares one single-port RAM between the JTAG monitor and an
// Avalon-MM host. Round-robin on conflict, one access per IDLE->ACC->RESP pass.
// JTAG requests are one-cycle strobes held in a single-entry pending register.
// Optional feature: define OCIMEM_AVS_WRPROT_EN to block Avalon writes to the
// top 16 RAM words (timing unchanged, RAM write suppressed).
module nios2_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic                   clk,
    input logic                   reset,
    nios2_ocimem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e            state_q, state_d;
    logic              jpend_q, jpend_d;
    logic              jp_wr_q, jp_wr_d;
    logic [ADDR_W-1:0] jp_addr_q, jp_addr_d;
    logic [DATA_W-1:0] jp_wdata_q, jp_wdata_d;
    logic              last_jtag_q, last_jtag_d;
    logic              acc_jtag_q, acc_jtag_d;
    logic              acc_wr_q, acc_wr_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] mondreg_q, mondreg_d;

    logic              jtag_pres, avs_pres, grant_jtag, grant_avs;
    logic              drop, accept, avs_prot;
    logic              src_wr;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;

    // A fresh strobe counts as a JTAG request in its own cycle; Avalon is never latched.
    assign jtag_pres = jpend_q | bus.jtag_req;
    assign avs_pres  = bus.avs_read | bus.avs_write;

`ifdef OCIMEM_AVS_WRPROT_EN
    assign avs_prot = &bus.avs_address[ADDR_W-1:4];
`else
    assign avs_prot = 1'b0;
`endif

    // Arbitration and state sequencing
    always_comb begin
        state_d    = state_q;
        grant_jtag = 1'b0;
        grant_avs  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (jtag_pres && (!avs_pres || !last_jtag_q)) begin
                    grant_jtag = 1'b1;
                end else if (avs_pres) begin
                    grant_avs = 1'b1;
                end
                if (grant_jtag || grant_avs) begin
                    state_d = StAcc;
                end
            end
            StAcc:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pending-register bookkeeping: older pending request is served before a new strobe
    always_comb begin
        src_wr     = jpend_q ? jp_wr_q    : bus.jtag_wr;
        src_addr   = jpend_q ? jp_addr_q  : bus.jtag_addr;
        src_wdata  = jpend_q ? jp_wdata_q : bus.jtag_wdata;
        drop       = bus.jtag_req & jpend_q & ~grant_jtag;
        accept     = bus.jtag_req & ~drop;
        jpend_d    = grant_jtag ? (jpend_q & bus.jtag_req) : (jpend_q | bus.jtag_req);
        jp_wr_d    = jp_wr_q;
        jp_addr_d  = jp_addr_q;
        jp_wdata_d = jp_wdata_q;
        if (bus.jtag_req && (grant_jtag ? jpend_q : !jpend_q)) begin
            jp_wr_d    = bus.jtag_wr;
            jp_addr_d  = bus.jtag_addr;
            jp_wdata_d = bus.jtag_wdata;
        end
    end

    // Capture the granted access and update the JTAG status registers
    always_comb begin
        acc_jtag_d  = acc_jtag_q;
        acc_wr_d    = acc_wr_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        last_jtag_d = last_jtag_q;
        if (grant_jtag) begin
            acc_jtag_d  = 1'b1;
            acc_wr_d    = src_wr;
            acc_addr_d  = src_addr;
            acc_wdata_d = src_wdata;
            last_jtag_d = 1'b1;
        end else if (grant_avs) begin
            acc_jtag_d  = 1'b0;
            acc_wr_d    = bus.avs_write & ~avs_prot;
            acc_addr_d  = bus.avs_address;
            acc_wdata_d = bus.avs_writedata;
            last_jtag_d = 1'b0;
        end

        ready_d   = ready_q;
        mondreg_d = mondreg_q;
        if (state_q == StResp && acc_jtag_q) begin
            ready_d = 1'b1;
            if (!acc_wr_q) begin
                mondreg_d = bus.ram_rdata;
            end
        end
        // A newly accepted request invalidates the previous completion.
        if (accept) begin
            ready_d = 1'b0;
        end

        error_d = error_q;
        if (drop) begin
            error_d = 1'b1;
        end else if (bus.jtag_clr_err) begin
            error_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            jpend_q     <= 1'b0;
            jp_wr_q     <= 1'b0;
            jp_addr_q   <= '0;
            jp_wdata_q  <= '0;
            last_jtag_q <= 1'b0;
            acc_jtag_q  <= 1'b0;
            acc_wr_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            mondreg_q   <= '0;
        end else begin
            state_q     <= state_d;
            jpend_q     <= jpend_d;
            jp_wr_q     <= jp_wr_d;
            jp_addr_q   <= jp_addr_d;
            jp_wdata_q  <= jp_wdata_d;
            last_jtag_q <= last_jtag_d;
            acc_jtag_q  <= acc_jtag_d;
            acc_wr_q    <= acc_wr_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            mondreg_q   <= mondreg_d;
        end
    end

    assign bus.ram_addr        = acc_addr_q;
    assign bus.ram_wdata       = acc_wdata_q;
    assign bus.ram_wr          = (state_q == StAcc) && acc_wr_q;
    assign bus.avs_waitrequest = !((state_q == StResp) && !acc_jtag_q);
    assign bus.avs_readdata    = bus.ram_rdata;
    assign bus.MonDReg         = mondreg_q;
    assign bus.monitor_ready   = ready_q;
    assign bus.monitor_error   = error_q;
endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: directed scenarios followed by
// random concurrent JTAG/Avalon traffic checked against a reference memory.
module tb_nios2_ocimem_arbiter;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
`ifdef OCIMEM_AVS_WRPROT_EN
    localparam bit Prot = 1'b1;
`else
    localparam bit Prot = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios2_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    nios2_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bench RAM (read latency 1) with a preload port
    logic [DW-1:0] mem [256];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_wr) wr_cnt <= wr_cnt + 1;
    end

    // Reference memory: what each address must hold given the bench's own writes
    logic [DW-1:0] ref_mem [256];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        cyc(1);
        pre_we = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.jtag_req = 0; bus.jtag_wr = 0; bus.jtag_addr = '0; bus.jtag_wdata = '0;
        bus.jtag_clr_err = 0; bus.avs_read = 0; bus.avs_write = 0;
        bus.avs_address = '0; bus.avs_writedata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_inputs();
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic jtag_drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.jtag_req = 1'b1; bus.jtag_wr = wr; bus.jtag_addr = a; bus.jtag_wdata = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        pre_we = 1'b0; idle_inputs();
        cyc(1);
        for (int a = 0; a < 256; a++) preload(AW'(a), $urandom);
        preload(8'h10, 32'hDEADBEEF);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check_eq("rst_ready", bus.monitor_ready, 0);
        check_eq("rst_error", bus.monitor_error, 0);
        check_eq("rst_mondreg", bus.MonDReg, 0);
        check_eq("rst_ram_wr", bus.ram_wr, 0);

        // JTAG read of 0x10: ready and data three cycles after the strobe
        jtag_drive(1'b0, 8'h10, '0);
        cyc(1); bus.jtag_req = 0;
        check_eq("t1_ram_addr", bus.ram_addr, 32'h10);
        check_eq("t1_ram_wr", bus.ram_wr, 0);
        check_eq("t1_ready_c1", bus.monitor_ready, 0);
        cyc(1);
        check_eq("t1_ready_c2", bus.monitor_ready, 0);
        cyc(1);
        check_eq("t1_ready_c3", bus.monitor_ready, 1);
        check_eq("t1_mondreg", bus.MonDReg, 32'hDEADBEEF);

        // Reset during ACC of a JTAG write, with a second request arriving
        jtag_drive(1'b1, 8'h51, 32'hA5A50051);
        cyc(1);
        check_eq("t5_acc_wr", bus.ram_wr, 1);
        ref_mem[8'h51] = 32'hA5A50051;
        jtag_drive(1'b1, 8'h52, 32'hA5A50052);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; idle_inputs();
        w0 = wr_cnt;
        check_eq("t5_ram_wr", bus.ram_wr, 0);
        check_eq("t5_ready", bus.monitor_ready, 0);
        check_eq("t5_error", bus.monitor_error, 0);
        check_eq("t5_mondreg", bus.MonDReg, 0);
        check_eq("t5_waitreq", bus.avs_waitrequest, 1);
        cyc(6);
        check_eq("t5_no_writes", wr_cnt - w0, 0);
        check_eq("t5_mem52", mem[8'h52], ref_mem[8'h52]);

        // Avalon write 0x22
        bus.avs_write = 1; bus.avs_address = 8'h22; bus.avs_writedata = 32'h12345678;
        w0 = wr_cnt;
        check_eq("t2_wait_c0", bus.avs_waitrequest, 1);
        cyc(1);
        check_eq("t2_ram_wr", bus.ram_wr, 1);
        check_eq("t2_ram_addr", bus.ram_addr, 32'h22);
        check_eq("t2_ram_wdata", bus.ram_wdata, 32'h12345678);
        check_eq("t2_wait_c1", bus.avs_waitrequest, 1);
        cyc(1);
        check_eq("t2_wait_c2", bus.avs_waitrequest, 0);
        check_eq("t2_ram_wr_c2", bus.ram_wr, 0);
        bus.avs_write = 0;
        ref_mem[8'h22] = 32'h12345678;
        cyc(1);
        check_eq("t2_wr_pulses", wr_cnt - w0, 1);
        check_eq("t2_mem", mem[8'h22], 32'h12345678);

        // Conflict after reset: JTAG first, then Avalon, repeat conflict to Avalon
        do_reset();
        jtag_drive(1'b0, 8'h30, '0);
        bus.avs_read = 1; bus.avs_address = 8'h31;
        cyc(1); bus.jtag_req = 0;
        check_eq("t3_jtag_first", bus.ram_addr, 32'h30);
        check_eq("t3_wait_c1", bus.avs_waitrequest, 1);
        cyc(1);
        check_eq("t3_wait_c2", bus.avs_waitrequest, 1);
        cyc(1);
        check_eq("t3_ready", bus.monitor_ready, 1);
        check_eq("t3_mondreg", bus.MonDReg, ref_mem[8'h30]);
        check_eq("t3_wait_c3", bus.avs_waitrequest, 1);
        jtag_drive(1'b0, 8'h32, '0);
        cyc(1); bus.jtag_req = 0;
        check_eq("t3_avs_second", bus.ram_addr, 32'h31);
        check_eq("t3_ready_clr", bus.monitor_ready, 0);
        cyc(1);
        check_eq("t3_avs_wait", bus.avs_waitrequest, 0);
        check_eq("t3_avs_rdata", bus.avs_readdata, ref_mem[8'h31]);
        bus.avs_read = 0;
        cyc(2);
        check_eq("t3_pend_third", bus.ram_addr, 32'h32);
        cyc(2);
        check_eq("t3_ready2", bus.monitor_ready, 1);
        check_eq("t3_mondreg2", bus.MonDReg, ref_mem[8'h32]);

        // Overrun: second strobe while the first is pending behind Avalon
        do_reset();
        bus.avs_write = 1; bus.avs_address = 8'h40; bus.avs_writedata = 32'h0000D040;
        w0 = wr_cnt;
        cyc(1);
        jtag_drive(1'b1, 8'h41, 32'h0000D041);
        cyc(1);
        check_eq("t4_avs_wait", bus.avs_waitrequest, 0);
        jtag_drive(1'b1, 8'h42, 32'h0000D042);
        cyc(1);
        bus.jtag_req = 0; bus.avs_write = 0;
        check_eq("t4_error_set", bus.monitor_error, 1);
        cyc(3);
        check_eq("t4_ready", bus.monitor_ready, 1);
        check_eq("t4_error_sticky", bus.monitor_error, 1);
        bus.jtag_clr_err = 1;
        cyc(1);
        bus.jtag_clr_err = 0;
        check_eq("t4_error_clr", bus.monitor_error, 0);
        check_eq("t4_wr_pulses", wr_cnt - w0, 2);
        check_eq("t4_mem41", mem[8'h41], 32'h0000D041);
        check_eq("t4_mem42", mem[8'h42], ref_mem[8'h42]);
        ref_mem[8'h40] = 32'h0000D040;
        ref_mem[8'h41] = 32'h0000D041;

        // Top-16 write: Avalon (protected when enabled) then JTAG (never protected)
        bus.avs_write = 1; bus.avs_address = 8'hF5; bus.avs_writedata = 32'h0000AF5A;
        cyc(1);
        check_eq("t6_avs_wr", bus.ram_wr, !Prot);
        check_eq("t6_wait_c1", bus.avs_waitrequest, 1);
        cyc(1);
        check_eq("t6_wait_c2", bus.avs_waitrequest, 0);
        bus.avs_write = 0;
        cyc(1);
        jtag_drive(1'b1, 8'hF5, 32'h0000F5F5);
        cyc(1); bus.jtag_req = 0;
        check_eq("t6_jtag_wr", bus.ram_wr, 1);
        ref_mem[8'hF5] = 32'h0000F5F5;
        cyc(2);
        check_eq("t6_mem", mem[8'hF5], 32'h0000F5F5);

        // Random concurrent traffic; JTAG uses 0x00-0x7F, Avalon 0x80-0xEF
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic          jw;
                    logic [AW-1:0] ja;
                    logic [DW-1:0] jd;
                    int            jn;
                    cyc($urandom_range(0, 3));
                    jw = 1'($urandom_range(0, 1));
                    ja = AW'($urandom_range(0, 127));
                    jd = $urandom;
                    jtag_drive(jw, ja, jd);
                    cyc(1); bus.jtag_req = 0;
                    check_eq("rnd_jtag_ready_clr", bus.monitor_ready, 0);
                    jn = 0;
                    while (!bus.monitor_ready && jn < 20) begin cyc(1); jn++; end
                    check_eq("rnd_jtag_done", 32'(jn < 20), 1);
                    if (jw) ref_mem[ja] = jd;
                    else check_eq("rnd_jtag_rd", bus.MonDReg, ref_mem[ja]);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    logic          aw;
                    logic [AW-1:0] aa;
                    logic [DW-1:0] ad;
                    int            an;
                    cyc($urandom_range(0, 3));
                    aw = 1'($urandom_range(0, 1));
                    aa = AW'(8'h80 + $urandom_range(0, 8'h6F));
                    ad = $urandom;
                    bus.avs_write = aw; bus.avs_read = !aw;
                    bus.avs_address = aa; bus.avs_writedata = ad;
                    cyc(1); an = 1;
                    while (bus.avs_waitrequest && an < 20) begin cyc(1); an++; end
                    check_eq("rnd_avs_done", 32'(an < 20), 1);
                    check_eq("rnd_avs_lat_min", 32'(an >= 2), 1);
                    if (aw) ref_mem[aa] = ad;
                    else check_eq("rnd_avs_rd", bus.avs_readdata, ref_mem[aa]);
                    bus.avs_write = 0; bus.avs_read = 0;
                end
            end
        join
        cyc(3);
        check_eq("rnd_error", bus.monitor_error, 0);
        for (int a = 0; a < 256; a++) check_eq("final_mem", mem[a], ref_mem[a]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
